// File: rtl/dvi_link_sequencer.sv
// dvi_link_sequencer: drives the three DVI TMDS encoders from raw display timing, gating video to whole frames
// Ports: i_clk/i_rst (sync, active-high); i_en link enable level; i_hsync/i_vsync/i_de/i_r/i_g/i_b raw timing and pixel;
//        o_de/o_ctrl_b/o_ctrl_g/o_ctrl_r/o_data_r/o_data_g/o_data_b encoder inputs; o_state link phase; o_frame_start frame pulse
module dvi_link_sequencer #(
  parameter int STARTUP_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_de,
  output logic [1:0] o_ctrl_b,
  output logic [1:0] o_ctrl_g,
  output logic [1:0] o_ctrl_r,
  output logic [7:0] o_data_r,
  output logic [7:0] o_data_g,
  output logic [7:0] o_data_b,
  output logic [1:0] o_state,
  output logic       o_frame_start
);
  localparam int CW = $clog2(STARTUP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, STARTUP, WAIT_FRAME, ACTIVE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic vsync_q, fb, fe, video, pix;
  assign fb = vsync_q & ~i_vsync;
  assign fe = ~vsync_q & i_vsync;
  assign video = state == ACTIVE || state == DRAIN;
  assign pix = video & i_de;
  // DRAIN is externally indistinguishable from ACTIVE
  assign o_state = state == DRAIN ? 2'd3 : state[1:0];
  assign o_ctrl_g = 2'b00;
  assign o_ctrl_r = 2'b00;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = i_en ? STARTUP : IDLE;
      STARTUP:    state_nxt = !i_en ? IDLE : cnt == CW'(STARTUP_CYCLES - 1) ? WAIT_FRAME : STARTUP;
      WAIT_FRAME: state_nxt = !i_en ? IDLE : fb ? ACTIVE : WAIT_FRAME;
      ACTIVE:     state_nxt = i_en ? ACTIVE : DRAIN;
      DRAIN:      state_nxt = i_en ? ACTIVE : fe ? IDLE : DRAIN;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      vsync_q       <= 1'b0;
      o_de          <= 1'b0;
      o_ctrl_b      <= 2'b00;
      o_data_r      <= 8'h00;
      o_data_g      <= 8'h00;
      o_data_b      <= 8'h00;
      o_frame_start <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= state == IDLE ? '0 : state == STARTUP ? cnt + CW'(1) : cnt;
      vsync_q       <= i_vsync;
      o_de          <= pix;
      o_ctrl_b      <= state == IDLE ? 2'b00 : {i_vsync, i_hsync};
      o_data_r      <= pix ? i_r : 8'h00;
      o_data_g      <= pix ? i_g : 8'h00;
      o_data_b      <= pix ? i_b : 8'h00;
      o_frame_start <= fb & (video | state == WAIT_FRAME);
    end
  end
endmodule

// File: tb/tb_dvi_link_sequencer.sv
// tb_dvi_link_sequencer: directed stimulus with a queued-expectation scoreboard for dvi_link_sequencer
module tb_dvi_link_sequencer;
  localparam int SC = 16;
  logic clk = 0, rst = 1, en = 0, hs = 0, vs = 0, de = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic o_de, o_frame_start;
  logic [1:0] o_ctrl_b, o_ctrl_g, o_ctrl_r, o_state;
  logic [7:0] o_data_r, o_data_g, o_data_b;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int at;
    string name;
    logic [1:0] st;
    logic de;
    logic [1:0] cb;
    logic [23:0] px;
    logic fs;
  } exp_t;
  exp_t q[$];
  exp_t x;
  dvi_link_sequencer #(.STARTUP_CYCLES(SC)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .i_r(r), .i_g(g), .i_b(b),
    .o_de(o_de), .o_ctrl_b(o_ctrl_b), .o_ctrl_g(o_ctrl_g), .o_ctrl_r(o_ctrl_r),
    .o_data_r(o_data_r), .o_data_g(o_data_g), .o_data_b(o_data_b),
    .o_state(o_state), .o_frame_start(o_frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      x = q.pop_front();
      checks++;
      if ({o_state, o_de, o_ctrl_b, o_ctrl_g, o_ctrl_r, o_data_r, o_data_g, o_data_b, o_frame_start} !==
          {x.st, x.de, x.cb, 4'b0000, x.px, x.fs}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got st=%0d de=%b cb=%b cg=%b cr=%b rgb=%h fs=%b, want st=%0d de=%b cb=%b cg=00 cr=00 rgb=%h fs=%b",
                 x.name, cyc, o_state, o_de, o_ctrl_b, o_ctrl_g, o_ctrl_r, {o_data_r, o_data_g, o_data_b}, o_frame_start,
                 x.st, x.de, x.cb, x.px, x.fs);
      end
    end
  end
  task automatic v(input string nm, input logic r_, e_, vs_, hs_, de_, input logic [23:0] px, input bit chk,
                   input logic [1:0] st, input logic ode, input logic [1:0] cb, input logic [23:0] opx, input logic fs);
    rst = r_; en = e_; vs = vs_; hs = hs_; de = de_;
    {r, g, b} = px;
    if (chk) q.push_back('{cyc + 1, nm, st, ode, cb, opx, fs});
    @(posedge clk);
    #1;
  endtask
  task automatic bringup(input string tag);
    v({tag, "_idle_exit"}, 0, 1, 0, 1, 1, 24'hffffff, 1, 2'd1, 0, 2'b00, 24'h0, 0);
    for (int k = 0; k < SC; k++)
      v({tag, "_startup"}, 0, 1, k[1], k[0], 1, 24'h777777, 1, k < SC - 1 ? 2'd1 : 2'd2, 0, {k[1], k[0]}, 24'h0, 0);
    v({tag, "_wait_de"}, 0, 1, 1, 0, 1, 24'haabbcc, 1, 2'd2, 0, 2'b10, 24'h0, 0);
    v({tag, "_release"}, 0, 1, 0, 0, 0, 24'h0, 1, 2'd3, 0, 2'b00, 24'h0, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    v("reset", 1, 1, 1, 1, 1, 24'hffffff, 1, 2'd0, 0, 2'b00, 24'h0, 0);
    v("idle_hold", 0, 0, 1, 1, 1, 24'hffffff, 1, 2'd0, 0, 2'b00, 24'h0, 0);
    bringup("b1");
    v("active_px", 0, 1, 0, 1, 1, 24'h123456, 1, 2'd3, 1, 2'b01, 24'h123456, 0);
    v("active_blank", 0, 1, 0, 0, 0, 24'hffffff, 1, 2'd3, 0, 2'b00, 24'h0, 0);
    v("active_fe", 0, 1, 1, 0, 0, 24'h0, 1, 2'd3, 0, 2'b10, 24'h0, 0);
    v("active_fb", 0, 1, 0, 1, 0, 24'h0, 1, 2'd3, 0, 2'b01, 24'h0, 1);
    v("drop", 0, 0, 0, 0, 1, 24'h111111, 1, 2'd3, 1, 2'b00, 24'h111111, 0);
    v("reraise", 0, 1, 0, 0, 0, 24'h0, 1, 2'd3, 0, 2'b00, 24'h0, 0);
    v("reraise_fe", 0, 1, 1, 0, 0, 24'h0, 1, 2'd3, 0, 2'b10, 24'h0, 0);
    v("reraise_fb", 0, 1, 0, 0, 0, 24'h0, 1, 2'd3, 0, 2'b00, 24'h0, 1);
    v("drop_at_fe", 0, 0, 1, 0, 0, 24'h0, 1, 2'd3, 0, 2'b10, 24'h0, 0);
    v("drain_px", 0, 0, 1, 1, 1, 24'h222222, 1, 2'd3, 1, 2'b11, 24'h222222, 0);
    v("drain_vs_low", 0, 0, 0, 0, 0, 24'h0, 0, 2'd0, 0, 2'b00, 24'h0, 0);
    v("drain_fe", 0, 0, 1, 0, 1, 24'h0a0b0c, 1, 2'd0, 1, 2'b10, 24'h0a0b0c, 0);
    v("idle_after", 0, 0, 1, 0, 1, 24'h333333, 1, 2'd0, 0, 2'b00, 24'h0, 0);
    bringup("b2");
    v("pre_rst", 0, 1, 0, 1, 1, 24'h123456, 1, 2'd3, 1, 2'b01, 24'h123456, 0);
    v("rst_mid", 1, 1, 0, 1, 1, 24'h123456, 1, 2'd0, 0, 2'b00, 24'h0, 0);
    bringup("b3");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
